// File: rtl/password_pkg.sv
// Shared definitions for the password checker: FSM state encodings and index-width helper.
package password_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    GRANTED = 2'd2,
    LOCKED  = 2'd3
  } pw_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/password_checker_if.sv
// Digit-entry bus between the button shaper / game controller and the password checker.
interface password_checker_if #(
  parameter int DIGIT_W = 4
);
  // Enter_pulse and Logout_pulse are single-cycle strobes with no backpressure;
  // Digit_in is only meaningful in the cycle Enter_pulse is high.
  logic               Enter_pulse;
  logic [DIGIT_W-1:0] Digit_in;
  logic               Logout_pulse;
  logic               Access_granted;
  logic               Access_denied;
  logic               Locked;
  logic [2:0]         Digit_count;

  modport master (
    output Enter_pulse, Digit_in, Logout_pulse,
    input  Access_granted, Access_denied, Locked, Digit_count
  );

  modport slave (
    input  Enter_pulse, Digit_in, Logout_pulse,
    output Access_granted, Access_denied, Locked, Digit_count
  );
endinterface

// File: rtl/lockout_timer.sv
// Load/count-down timer; done is high in the last of CYCLES cycles after a load.
module lockout_timer
  import password_pkg::*;
#(
  parameter int CYCLES = 100
) (
  input  logic Clk,
  input  logic rts,
  input  logic load,
  output logic done
);

  localparam int W = idx_width(CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge rts) begin
    if (!rts) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/password_checker.sv
// Collects DIGITS switch digits and grants or denies access against a stored password.
// Optional lockout after MAX_FAIL consecutive failures is enabled by defining PW_LOCKOUT_EN.
module password_checker
  import password_pkg::*;
#(
  parameter int                        DIGITS    = 4,
  parameter int                        DIGIT_W   = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] PASSWORD  = 16'h5293,
  parameter int                        MAX_FAIL  = 3
`ifdef PW_LOCKOUT_EN
  ,
  parameter int                        LOCK_CYCLES = 100
`endif
) (
  input  logic               Clk,
  input  logic               rts,
  password_checker_if.slave  bus,
  output pw_state_t          state_dbg
);

  localparam int IDX_W  = idx_width(DIGITS);
  localparam int FAIL_W = idx_width(MAX_FAIL + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  pw_state_t          state, state_n;
  logic [IDX_W-1:0]   count, count_n;
  logic               mismatch, mismatch_n;
  logic [FAIL_W-1:0]  fail_cnt, fail_n;
  logic               granted, granted_n;
  logic               denied, denied_n;
  logic               locked, locked_n;
  logic [DIGIT_W-1:0] exp_digit;

`ifdef PW_LOCKOUT_EN
  logic timer_load;
  logic timer_done;

  lockout_timer #(.CYCLES(LOCK_CYCLES)) u_lockout_timer (
    .Clk  (Clk),
    .rts  (rts),
    .load (timer_load),
    .done (timer_done)
  );
`endif

  // Most significant digit is entered first, so index 0 selects the top nibble.
  always_comb begin
    exp_digit = DIGIT_W'(PASSWORD >> (DIGIT_W * (DIGITS - 1 - int'(count))));
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    mismatch_n = mismatch;
    fail_n     = fail_cnt;
    granted_n  = granted;
    denied_n   = 1'b0;
    locked_n   = locked;
`ifdef PW_LOCKOUT_EN
    timer_load = 1'b0;
`endif
    case (state)
      COLLECT: begin
        if (bus.Logout_pulse) begin
          count_n    = '0;
          mismatch_n = 1'b0;
        end else if (bus.Enter_pulse) begin
          mismatch_n = mismatch | (bus.Digit_in != exp_digit);
          if (count == LAST_IDX) begin
            count_n = '0;
            state_n = CHECK;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      CHECK: begin
        mismatch_n = 1'b0;
        if (!mismatch) begin
          state_n   = GRANTED;
          granted_n = 1'b1;
          fail_n    = '0;
        end else begin
          denied_n = 1'b1;
          fail_n   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
          state_n  = COLLECT;
`ifdef PW_LOCKOUT_EN
          if (fail_n == FAIL_MAX) begin
            state_n    = LOCKED;
            locked_n   = 1'b1;
            timer_load = 1'b1;
          end
`endif
        end
      end
      GRANTED: begin
        if (bus.Logout_pulse) begin
          state_n   = COLLECT;
          granted_n = 1'b0;
        end
      end
`ifdef PW_LOCKOUT_EN
      LOCKED: begin
        if (timer_done) begin
          state_n  = COLLECT;
          locked_n = 1'b0;
          fail_n   = '0;
        end
      end
`endif
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge rts) begin
    if (!rts) begin
      state    <= COLLECT;
      count    <= '0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      granted  <= 1'b0;
      denied   <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      mismatch <= mismatch_n;
      fail_cnt <= fail_n;
      granted  <= granted_n;
      denied   <= denied_n;
      locked   <= locked_n;
    end
  end

  assign bus.Access_granted = granted;
  assign bus.Access_denied  = denied;
  assign bus.Locked         = locked;
  assign bus.Digit_count    = 3'(count);
  assign state_dbg          = state;

endmodule
